pipeline_stall_ctrl: RTL
========================

Name: pipeline_stall_ctrl

Overview:
Central stall/flush controller for the 5-stage pipeline. It is the consumer of the load-use hazard flag from the ID-stage hazard detector. It combines that flag with the EX-stage branch redirect and the data-memory busy signal, and drives the PC, IF/ID and ID/EX write/bubble controls. A small FSM handles multi-cycle flushes, memory-wait freezes and a memory watchdog.

Parameters:
FLUSH_CYCLES, 1, total cycles of IF/ID squash per taken branch (1..7).
TIMEOUT, 64, max consecutive dmem_busy_i cycles before watchdog trip; 0 disables the watchdog.
CNT_W, 8, watchdog counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
clk_i  input  1  clock, rising edge
rst_n_i  input  1  asynchronous active-low reset
hazard_i  input  1  load-use hazard from the ID-stage hazard detector
branch_taken_i  input  1  EX-stage taken branch/jump (redirect)
dmem_busy_i  input  1  data memory not ready this cycle
pc_write_o  output  1  PC register write enable
if_id_write_o  output  1  IF/ID register write enable
if_id_flush_o  output  1  clear IF/ID to NOP
id_ex_bubble_o  output  1  force ID/EX control fields to zero
pipe_hold_o  output  1  hold ID/EX, EX/MEM, MEM/WB
mem_timeout_o  output  1  sticky watchdog error
stall_cycles_o  output  32  perf counter, load-use plus mem-wait cycles (see optional feature)
flush_cycles_o  output  32  perf counter, flush cycles (see optional feature)

Behaviour:
- One clock; reset is asynchronous and active-low. rst_n_i low forces state RUN, all counters 0, mem_timeout_o=0.
- Outputs are combinational from the registered state and the current inputs. While rst_n_i is low, outputs are forced: pc_write_o=0, if_id_write_o=0, if_id_flush_o=1, id_ex_bubble_o=1, pipe_hold_o=0.
- Default (RUN, no event): pc_write_o=1, if_id_write_o=1, others 0.
- Priority in every state: ERROR > dmem_busy_i > branch_taken_i > hazard_i.
- RUN:
  - dmem_busy_i=1: pc_write_o=0, if_id_write_o=0, pipe_hold_o=1, no bubble, no flush. Next state MEM_WAIT; wd_cnt=1; ret_state=RUN.
  - branch_taken_i=1: pc_write_o=1, if_id_flush_o=1, id_ex_bubble_o=1. If FLUSH_CYCLES>1, next state FLUSH with fl_cnt=FLUSH_CYCLES-1; else stay in RUN.
  - hazard_i=1: pc_write_o=0, if_id_write_o=0, id_ex_bubble_o=1, no flush. Stay in RUN. The bubble clears the hazard next cycle; no internal guard is needed.
- FLUSH: outputs equal the branch case. fl_cnt decrements each cycle; at fl_cnt==1, next state is RUN. hazard_i is ignored (wrong path). A new branch_taken_i reloads fl_cnt=FLUSH_CYCLES-1. dmem_busy_i=1 overrides: freeze outputs as in the RUN busy case, next state MEM_WAIT, ret_state=FLUSH, fl_cnt preserved and not decremented.
- MEM_WAIT: freeze outputs while dmem_busy_i=1; wd_cnt increments and saturates.
  - TIMEOUT!=0 and wd_cnt==TIMEOUT with busy still high: next state ERROR.
  - Cycle in which dmem_busy_i=0: outputs evaluated as in ret_state with current inputs (the pipeline advances). Next state is ret_state or its successor; wd_cnt=0.
- ERROR: mem_timeout_o=1; pc_write_o=0, if_id_write_o=0, pipe_hold_o=1. Leaves only on reset.
- wd_cnt restarts at 1 on every new busy episode.

Optional Feature:
STALL_PERF_EN defined: two 32-bit wrapping counters.
- stall_cycles_o increments on every cycle where pc_write_o=0 and state!=ERROR.
- flush_cycles_o increments on every cycle where if_id_flush_o=1 and rst_n_i=1.
- Both clear on reset.
Undefined: both ports are tied to 0 and no counter flops are built.

Test Plan:
- Reset: hold rst_n_i=0 for 3 cycles with random inputs -> pc_write_o=0, if_id_flush_o=1, id_ex_bubble_o=1, mem_timeout_o=0; first cycle after release with idle inputs gives pc_write_o=1, if_id_write_o=1.
- Load-use: hazard_i=1 for 1 cycle -> same cycle pc_write_o=0, if_id_write_o=0, id_ex_bubble_o=1; next cycle with hazard_i=0 -> normal; with STALL_PERF_EN, stall_cycles_o=1.
- Flush: FLUSH_CYCLES=3, branch_taken_i pulse -> if_id_flush_o=1, id_ex_bubble_o=1, pc_write_o=1 for exactly 3 cycles, then RUN; hazard_i=1 in cycle 2 has no effect.
- Busy mid-flush: FLUSH_CYCLES=3, branch then dmem_busy_i=1 for 4 cycles starting flush cycle 2 -> 4 frozen cycles (pipe_hold_o=1, if_id_flush_o=0); flush then resumes for the remaining 2 cycles.
- Simultaneous events: dmem_busy_i, branch_taken_i and hazard_i all 1 -> freeze only; busy drops with branch still 1 -> flush that cycle.
- Watchdog: TIMEOUT=5, dmem_busy_i held high -> ERROR entered after the 5th busy cycle, mem_timeout_o=1 sticky after busy drops; asserting rst_n_i=0 clears it asynchronously.

Source files
------------

// File: rtl/pipeline_stall_ctrl_if.sv
// Stall/flush controller bus: hazard and memory-status inputs from the
// pipeline, write-enable / bubble / flush controls and status back to it.
// The controller uses the slave modport; the pipeline side uses master.
interface pipeline_stall_ctrl_if;
  logic        hazard_i;
  logic        branch_taken_i;
  logic        dmem_busy_i;
  logic        pc_write_o;
  logic        if_id_write_o;
  logic        if_id_flush_o;
  logic        id_ex_bubble_o;
  logic        pipe_hold_o;
  logic        mem_timeout_o;
  logic [31:0] stall_cycles_o;
  logic [31:0] flush_cycles_o;

  modport master (
    output hazard_i, branch_taken_i, dmem_busy_i,
    input  pc_write_o, if_id_write_o, if_id_flush_o, id_ex_bubble_o,
           pipe_hold_o, mem_timeout_o, stall_cycles_o, flush_cycles_o
  );

  modport slave (
    input  hazard_i, branch_taken_i, dmem_busy_i,
    output pc_write_o, if_id_write_o, if_id_flush_o, id_ex_bubble_o,
           pipe_hold_o, mem_timeout_o, stall_cycles_o, flush_cycles_o
  );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline.
// Priority: ERROR > dmem busy > branch redirect > load-use hazard.
// Optional macro STALL_PERF_EN builds the stall/flush perf counters;
// without it both counter ports are tied to zero.
module pipeline_stall_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned TIMEOUT      = 64,
  parameter int unsigned CNT_W        = 8
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  pipeline_stall_ctrl_if.slave ctrl
);

  typedef enum logic [1:0] {RUN, FLUSH, MEM_WAIT, ERROR} state_e;

  localparam logic [2:0]       FL_RELOAD = 3'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] WD_LIMIT  = CNT_W'(TIMEOUT);

  state_e           state_q, state_d;
  state_e           ret_q, ret_d;
  state_e           eff;
  logic [2:0]       fl_cnt_q, fl_cnt_d;
  logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d, wd_inc;
  logic             pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold;

  // Next state and combinational controls; a MEM_WAIT cycle that sees busy
  // drop is evaluated as the saved return state so the pipeline advances.
  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    pipe_hold    = 1'b0;
    state_d      = state_q;
    ret_d        = ret_q;
    fl_cnt_d     = fl_cnt_q;
    wd_cnt_d     = wd_cnt_q;
    eff          = (state_q == MEM_WAIT) ? ret_q : state_q;
    wd_inc       = (wd_cnt_q == '1) ? wd_cnt_q : wd_cnt_q + CNT_W'(1);

    if (state_q == ERROR) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      pipe_hold   = 1'b1;
    end else if (ctrl.dmem_busy_i) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      pipe_hold   = 1'b1;
      if (state_q == MEM_WAIT) begin
        wd_cnt_d = wd_inc;
        if ((TIMEOUT != 0) && (wd_inc >= WD_LIMIT)) state_d = ERROR;
      end else begin
        state_d  = MEM_WAIT;
        ret_d    = state_q;
        wd_cnt_d = CNT_W'(1);
      end
    end else begin
      wd_cnt_d = '0;
      state_d  = eff;
      if (ctrl.branch_taken_i) begin
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
        if (FLUSH_CYCLES > 1) begin
          state_d  = FLUSH;
          fl_cnt_d = FL_RELOAD;
        end else begin
          state_d  = RUN;
        end
      end else if (eff == FLUSH) begin
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
        if (fl_cnt_q <= 3'd1) state_d  = RUN;
        else                  fl_cnt_d = fl_cnt_q - 3'd1;
      end else if (ctrl.hazard_i) begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_bubble = 1'b1;
      end
    end
  end

  // State, return-state, flush and watchdog counters.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= RUN;
      ret_q    <= RUN;
      fl_cnt_q <= '0;
      wd_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      ret_q    <= ret_d;
      fl_cnt_q <= fl_cnt_d;
      wd_cnt_q <= wd_cnt_d;
    end
  end

  assign ctrl.pc_write_o     = rst_n_i & pc_write;
  assign ctrl.if_id_write_o  = rst_n_i & if_id_write;
  assign ctrl.if_id_flush_o  = ~rst_n_i | if_id_flush;
  assign ctrl.id_ex_bubble_o = ~rst_n_i | id_ex_bubble;
  assign ctrl.pipe_hold_o    = rst_n_i & pipe_hold;
  assign ctrl.mem_timeout_o  = (state_q == ERROR);

`ifdef STALL_PERF_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  // Wrapping perf counters for stall and flush cycles.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!pc_write && (state_q != ERROR)) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (if_id_flush)                     flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign ctrl.stall_cycles_o = stall_cnt_q;
  assign ctrl.flush_cycles_o = flush_cnt_q;
`else
  assign ctrl.stall_cycles_o = '0;
  assign ctrl.flush_cycles_o = '0;
`endif

endmodule
